// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - instruction-memory request/response bundle between the fetch stage and imem
interface if_id_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_rdata;

    // Fetch stage drives the request; memory returns ack/data
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - VLIW fetch stage with IF/ID pipeline register, skid buffer and redirect drain
module if_id_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [63:0] NOP_BUNDLE = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_write,
    input  logic          if_id_write,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    if_id_stage_if.master imem,
    output logic [31:0]   if_id_pc,
    output logic [63:0]   if_id_instr,
    output logic          if_id_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [63:0] skid_data_q, skid_data_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [63:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        outstanding_q, outstanding_d;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        advance;

    // Request side: a raised request is held at a fixed address until acked; DRAIN keeps the pre-redirect address
    always_comb begin
        req  = 1'b0;
        addr = pc_q;
        case (state_q)
            FETCH: req = pc_write | outstanding_q;
            HOLD:  req = 1'b0;
            DRAIN: begin
                req  = 1'b1;
                addr = drain_addr_q;
            end
            default: req = 1'b0;
        endcase
        if (reset) begin
            req = 1'b0;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;
    assign ack            = req & imem.imem_ack;
    assign advance        = pc_write & if_id_write;

    // Next-state: redirect overrides stalls; otherwise fetch, skid-hold or drain the abandoned request
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        skid_data_d   = skid_data_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        outstanding_d = req & ~imem.imem_ack;

        if (branch_taken) begin
            pc_d          = branch_target & 32'hFFFF_FFF8;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_BUNDLE;
            if (req && !ack) begin
                state_d = DRAIN;
                if (state_q == FETCH) begin
                    drain_addr_d = pc_q;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack && advance) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = imem.imem_rdata;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd8;
                    end else begin
                        if (ack) begin
                            // Bundle arrived during a stall: park it; pc_q still names it
                            skid_data_d = imem.imem_rdata;
                            state_d     = HOLD;
                        end
                        if (if_id_write) begin
                            if_id_valid_d = 1'b0;
                            if_id_instr_d = NOP_BUNDLE;
                        end
                    end
                end
                HOLD: begin
                    // IF/ID is left untouched until the stall releases both enables
                    if (advance) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = skid_data_q;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd8;
                        state_d       = FETCH;
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        state_d = FETCH;
                    end
                    if (if_id_write) begin
                        if_id_valid_d = 1'b0;
                        if_id_instr_d = NOP_BUNDLE;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State and pipeline registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            drain_addr_q  <= 32'h0;
            skid_data_q   <= 64'h0;
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP_BUNDLE;
            if_id_valid_q <= 1'b0;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            skid_data_q   <= skid_data_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage against a transaction-level fetch model
module tb_if_id_stage;
    localparam logic [63:0] NOP0 = 64'h0000_0013_0000_0013;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF0;

    typedef struct {
        int          cyc;
        logic        rst;
        logic        v;
        logic [31:0] pc;
        logic [63:0] instr;
    } exp_t;

    logic        clk;
    logic        reset, pc_write, if_id_write, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] d0_pc, d1_pc;
    logic [63:0] d0_instr, d1_instr;
    logic        d0_valid, d1_valid;

    if_id_stage_if m0();
    if_id_stage_if m1();

    if_id_stage #(.RESET_PC(32'h0), .NOP_BUNDLE(NOP0)) dut0 (
        .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem(m0),
        .if_id_pc(d0_pc), .if_id_instr(d0_instr), .if_id_valid(d0_valid)
    );

    if_id_stage #(.RESET_PC(RPC1)) dut1 (
        .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem(m1),
        .if_id_pc(d1_pc), .if_id_instr(d1_instr), .if_id_valid(d1_valid)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Reference model: architectural fetch pointer, one in-flight request, one parked bundle
    logic [31:0] m_pc = 32'h0;
    logic        m_busy = 1'b0;
    logic [31:0] m_busy_addr = 32'h0;
    logic        m_disc = 1'b0;
    logic        m_buf_v = 1'b0;
    logic [63:0] m_buf = 64'h0;
    logic        m_v = 1'b0;
    logic [31:0] m_opc = 32'h0;
    logic [63:0] m_instr = NOP0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: IF/ID is presented every cycle; compare against the entry scheduled for this cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #2;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (d0_valid !== mon_e.v) begin
                errors++;
                $display("FAIL if_id_valid cyc=%0d got=%b exp=%b", cyc, d0_valid, mon_e.v);
            end
            checks++;
            if (d0_instr !== mon_e.instr) begin
                errors++;
                $display("FAIL if_id_instr cyc=%0d got=%h exp=%h", cyc, d0_instr, mon_e.instr);
            end
            if (mon_e.v || mon_e.rst) begin
                checks++;
                if (d0_pc !== mon_e.pc) begin
                    errors++;
                    $display("FAIL if_id_pc cyc=%0d got=%h exp=%h", cyc, d0_pc, mon_e.pc);
                end
            end
        end
    end

    task automatic bubble(input logic iw);
        if (iw) begin
            m_v     = 1'b0;
            m_instr = NOP0;
        end
    endtask

    // One clock of stimulus: drive, check the memory request, advance the model, schedule IF/ID expectation
    task automatic step(input logic rst, input logic pw, input logic iw, input logic br,
                        input logic [31:0] tgt, input logic ak);
        logic [63:0] rd;
        logic        m_req;
        logic [31:0] m_addr;
        exp_t        e;
        @(negedge clk);
        rd            = {$urandom, $urandom};
        reset         = rst;
        pc_write      = pw;
        if_id_write   = iw;
        branch_taken  = br;
        branch_target = tgt;
        m0.imem_ack   = ak;
        m0.imem_rdata = rd;
        m1.imem_ack   = ak;
        m1.imem_rdata = rd;
        #1;
        m_req  = !rst && !m_buf_v && (m_busy || pw);
        m_addr = m_busy ? m_busy_addr : m_pc;
        checks++;
        if (m0.imem_req !== m_req) begin
            errors++;
            $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, m0.imem_req, m_req);
        end
        if (m_req) begin
            checks++;
            if (m0.imem_addr !== m_addr) begin
                errors++;
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, m0.imem_addr, m_addr);
            end
        end
        if (rst) begin
            m_pc = 32'h0; m_busy = 1'b0; m_disc = 1'b0; m_buf_v = 1'b0;
            m_v = 1'b0; m_opc = 32'h0; m_instr = NOP0;
        end else if (br) begin
            m_pc        = {tgt[31:3], 3'b000};
            m_v         = 1'b0;
            m_instr     = NOP0;
            m_buf_v     = 1'b0;
            m_busy      = m_req && !ak;
            m_busy_addr = m_addr;
            m_disc      = m_busy;
        end else if (m_req && ak) begin
            if (m_disc) begin
                bubble(iw);
            end else if (pw && iw) begin
                m_v = 1'b1; m_opc = m_pc; m_instr = rd;
                m_pc = m_pc + 32'd8;
            end else begin
                m_buf_v = 1'b1; m_buf = rd;
                bubble(iw);
            end
            m_busy = 1'b0;
            m_disc = 1'b0;
        end else if (m_buf_v) begin
            if (pw && iw) begin
                m_v = 1'b1; m_opc = m_pc; m_instr = m_buf;
                m_pc = m_pc + 32'd8;
                m_buf_v = 1'b0;
            end
        end else begin
            m_busy      = m_req;
            m_busy_addr = m_addr;
            bubble(iw);
        end
        e = '{cyc + 1, rst, m_v, m_opc, m_instr};
        sb.push_back(e);
    endtask

    task automatic do_reset();
        step(1, 1, 1, 1, 32'h55, 1);
        step(1, 1, 1, 0, 32'h0, 1);
    endtask

    initial begin
        reset = 1'b1; pc_write = 1'b1; if_id_write = 1'b1; branch_taken = 1'b0;
        branch_target = 32'h0;
        m0.imem_ack = 1'b0; m0.imem_rdata = 64'h0;
        m1.imem_ack = 1'b0; m1.imem_rdata = 64'h0;

        // Continuous acks; the second instance also exercises the 32-bit wrap of the fetch address
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0, 32'h0, 1);
            if (i < 4) begin
                checks++;
                if (m1.imem_req !== 1'b1 || m1.imem_addr !== RPC1 + 32'(8 * i)) begin
                    errors++;
                    $display("FAIL wrap_addr i=%0d got=%b/%h exp=1/%h", i, m1.imem_req, m1.imem_addr, RPC1 + 32'(8 * i));
                end
            end
            if (i >= 1 && i < 4) begin
                checks++;
                if (d1_valid !== 1'b1 || d1_pc !== RPC1 + 32'(8 * (i - 1))) begin
                    errors++;
                    $display("FAIL wrap_pc i=%0d got=%b/%h exp=1/%h", i, d1_valid, d1_pc, RPC1 + 32'(8 * (i - 1)));
                end
            end
        end

        // Ack at pc=16 during a three-cycle stall, then release
        do_reset();
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);

        // Redirect while the pc=8 request is outstanding, drained for two cycles
        do_reset();
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 32'h105, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);

        // Redirect coincident with ack at pc=40 while IF/ID write is held off
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 1, 32'h0000_2468, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);

        // Reset while a bundle sits in the skid buffer
        do_reset();
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) == 0),
                 $urandom,
                 ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset (bits [2:0] zero).
REQ-002 Parameter NOP_BUNDLE, default 64'h0, value loaded into if_id_instr on reset or flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 pc_write  input  1  from hazard unit; 0 = hold PC and suppress new fetch.
REQ-006 if_id_write  input  1  from hazard unit; 0 = hold IF/ID register contents.
REQ-007 branch_taken  input  1  redirect request from EX; flushes this stage.
REQ-008 branch_target  input  32  redirect address; bits [2:0] ignored (treated as 0).
REQ-009 imem_req  output  1  instruction-memory request; held high until imem_ack.
REQ-010 imem_addr  output  32  bundle address; stable while imem_req high.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req low.
REQ-012 imem_rdata  input  64  two-slot VLIW bundle {slot1[63:32], slot0[31:0]}.
REQ-013 if_id_pc  output  32  PC of bundle held in IF/ID.
REQ-014 if_id_instr  output  64  bundle held in IF/ID.
REQ-015 if_id_valid  output  1  IF/ID holds a real bundle (0 = bubble).

Function
REQ-016 PC register SHALL advance by 8 per accepted bundle, wrapping modulo 2^32 (32'hFFFF_FFF8 + 8 = 0).
REQ-017 FSM states SHALL be FETCH, HOLD, DRAIN; state after reset SHALL be FETCH.
REQ-018 FETCH: imem_req=1 and imem_addr=pc, except imem_req=0 while pc_write=0 and no request is outstanding.
REQ-019 FETCH, imem_ack=1, pc_write=1, if_id_write=1: IF/ID <= {pc, imem_rdata}, if_id_valid<=1, pc<=pc+8, stay FETCH (back-to-back bundles every acked cycle).
REQ-020 FETCH, imem_ack=1, stall (pc_write=0 or if_id_write=0): capture {pc, imem_rdata} into a one-entry skid buffer, go HOLD; no data lost.
REQ-021 FETCH, no ack, if_id_write=1: if_id_valid<=0 (bubble), if_id_instr<=NOP_BUNDLE; if_id_write=0: IF/ID unchanged.
REQ-022 HOLD: imem_req=0; when pc_write=1 and if_id_write=1, IF/ID <= skid buffer, if_id_valid<=1, pc<=pc+8, go FETCH.
REQ-023 Once imem_req rises it SHALL stay high with unchanged imem_addr until imem_ack, regardless of pc_write.
REQ-024 branch_taken=1 SHALL override stall inputs: pc<={branch_target[31:3],3'b0}, if_id_valid<=0, if_id_instr<=NOP_BUNDLE, skid buffer discarded.
REQ-025 branch_taken in FETCH with request outstanding and no ack: go DRAIN; DRAIN keeps imem_req=1 at old address, discards data on ack, then goes FETCH at redirected pc.
REQ-026 branch_taken same cycle as imem_ack: returned bundle discarded, next state FETCH at target.
REQ-027 branch_taken in HOLD or DRAIN: pc updated to newest target; DRAIN continues to drain, HOLD goes FETCH.
REQ-028 Latency: bundle appears on IF/ID outputs the cycle after its ack (or after stall release from HOLD).
REQ-029 if_id_pc/if_id_instr SHALL change only when if_id_write=1, branch_taken=1, or reset.

Reset
REQ-030 With reset=1 at a clock edge: pc<=RESET_PC, state<=FETCH, if_id_valid<=0, if_id_pc<=0, if_id_instr<=NOP_BUNDLE, skid buffer empty.
REQ-031 imem_req SHALL be 0 during any cycle reset=1; reset mid-request abandons it (memory tolerates this).
REQ-032 reset SHALL take priority over branch_taken and all other inputs.

Verification
REQ-033 Reset then imem_ack every cycle, rdata=addr-tagged: if_id_pc sequence 0,8,16,24, valid=1 each cycle from cycle 2.
REQ-034 Ack at pc=16 with if_id_write=0,pc_write=0 for 3 cycles: state HOLD, imem_req=0, IF/ID holds pc=8; on release IF/ID pc=16, then fetch of 24.
REQ-035 Request at pc=8 outstanding, branch_taken with target 32'h105: pc=32'h100, DRAIN until ack (data dropped, valid=0), next request addr 32'h100.
REQ-036 branch_taken coincident with ack at pc=40 and if_id_write=0: valid=0, instr=NOP_BUNDLE, next imem_addr=target.
REQ-037 RESET_PC=32'hFFFF_FFF0, continuous ack: addresses FFFF_FFF0, FFFF_FFF8, 0000_0000.
REQ-038 Reset asserted in HOLD with buffered bundle: next cycle valid=0, pc=RESET_PC, buffer never emitted.
